data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised, byte-addressable data memory for the RISC-V processor datapath, successor to the single-word data memory. Accepts one load/store request at a time over a valid/ready handshake. Supports RV64I access sizes (byte, half, word, double) with sign/zero extension and partial-word stores. Returns the result after a programmable fixed latency, with misalignment and access-fault flags for the trap logic.

## Interface
- WORDSIZE, 64, data/address width in bits; legal values 32 or 64
- DEPTH, 1024, number of WORDSIZE-bit words in the array
- LATENCY, 1, cycles from request accept to response; legal range 1..8
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- addr  input  WORDSIZE  byte address
- write_en  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal
- data_input  input  WORDSIZE  store data; low bytes are used for sub-word stores
- resp_valid  output  1  one-cycle response pulse
- data_output  output  WORDSIZE  load result, extended per funct3; 0 for stores and faults
- misaligned  output  1  addr is not a multiple of access size; valid with resp_valid
- access_fault  output  1  out-of-range address or illegal funct3; valid with resp_valid

## Operation
- Accept when req_valid && req_ready. On accept, latch addr, write_en, funct3, and data_input. Inputs are don't-care otherwise.
- Access size: 1, 2, 4, or 8 bytes from funct3[1:0].
- Byte lane: addr[log2(WORDSIZE/8)-1:0]. Word index: addr >> log2(WORDSIZE/8).
- Fault precedence:
  - access_fault if funct3 = 111.
  - access_fault if WORDSIZE = 32 and funct3 is 011 or 110.
  - access_fault if word index >= DEPTH.
  - Otherwise misaligned if the byte lane is not a multiple of the size.
  - Only one flag is set per response.
- Faulting store: no array write. Faulting load: data_output = 0.
- Store: read-modify-write of the enabled byte lanes only; other bytes are preserved.
- Load: extract the lanes, then sign-extend (funct3[2] = 0) or zero-extend (funct3[2] = 1) to WORDSIZE.
- FSM states:
  - IDLE: req_ready = 1. On accept, go to WAIT if LATENCY > 1, else RESP.
  - WAIT: counter loads LATENCY-2 and decrements; go to RESP when it reaches 0.
  - RESP: resp_valid = 1, outputs valid; next state IDLE.
- The array write commits on the clock edge entering RESP. A load accepted afterwards sees the new data.
- Memory contents are not initialised and are not cleared by rst.

## Timing
- Request accepted in cycle t: resp_valid = 1 in cycle t+LATENCY only.
- req_ready = 0 during cycles t+1..t+LATENCY, and 1 again at t+LATENCY+1.
- Maximum throughput is one request per LATENCY+1 cycles.
- req_valid while req_ready = 0 is ignored; the requester holds it.
- Reset values: req_ready = 1 (from the cycle after rst), resp_valid = 0, data_output = 0, misaligned = 0, access_fault = 0, state IDLE, counter 0.
- rst during WAIT or in the accept cycle: the request is dropped, with no array write and no response.
- rst in the RESP cycle: the array write has already committed; outputs are 0 from the next cycle.
- data_output and the flags hold 0 outside RESP.

## Structure
- Package riscv_mem_pkg holds:
  - funct3 constants (F3_LB..F3_LWU)
  - the size-decode function
  - the state enum (IDLE, WAIT, RESP)
- Sub-module mem_byte_align: combinational.
  - Store side: lane steering plus byte-enable generation.
  - Load side: lane extraction plus sign/zero extension.
  - Parametrised by WORDSIZE.
- Top level: FSM, latency counter, request latches, array.

## Test plan
All scenarios use WORDSIZE=64, DEPTH=1024, LATENCY=2.
- SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> resp_valid at t+2, data_output 0x8877665544332211, no flags.
- After the above: SB 0x13 data 0xAB; then LB 0x13 -> 0xFFFFFFFFFFFFFFAB; LBU 0x13 -> 0xAB; LD 0x10 -> 0x88776655AB332211.
- LH 0x11 -> misaligned = 1, data_output 0. SW 0x11 data 0xDEADBEEF -> misaligned = 1, then LD 0x10 is unchanged.
- LD addr 0x2000 (word index 1024) -> access_fault = 1. Any access with funct3 = 111 -> access_fault = 1, misaligned = 0.
- req_valid held high for 6 cycles -> req_ready pattern 1,0,0,1,0,0 and exactly two responses (t+2, t+5).
- SD 0x18 data 0x1, then rst = 1 in cycle t+1 -> no resp_valid, all outputs 0. After the earlier SD 0x18 data 0x5, LD 0x18 returns 0x5.

Source files
------------

// File: rtl/data_memory_sized_pkg.sv
// rtl/data_memory_sized_pkg.sv - shared funct3 codes, access-size decode and FSM states
// Purpose: common definitions for the sized data memory.
// Contents: F3_* funct3 constants, access_size() decode, state_t enum.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_ILL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Access size in bytes (1, 2, 4 or 8) from the low two funct3 bits.
   function automatic logic [3:0] access_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   access_size = 4'd1;
         2'b01:   access_size = 4'd2;
         2'b10:   access_size = 4'd4;
         default: access_size = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// rtl/data_memory_sized_if.sv - request/response bundle for the sized data memory
// Purpose: groups the load/store handshake and response signals.
// Signals: req_valid/req_ready, addr, write_en, funct3, data_input (request);
//          resp_valid, data_output, misaligned, access_fault (response).
// Modports: master drives requests, slave is the memory.
interface data_memory_sized_if #(
   parameter int WORDSIZE = 64
);
   logic                req_valid;
   logic                req_ready;
   logic [WORDSIZE-1:0] addr;
   logic                write_en;
   logic [2:0]          funct3;
   logic [WORDSIZE-1:0] data_input;
   logic                resp_valid;
   logic [WORDSIZE-1:0] data_output;
   logic                misaligned;
   logic                access_fault;

   modport master (
      output req_valid, addr, write_en, funct3, data_input,
      input  req_ready, resp_valid, data_output, misaligned, access_fault
   );

   modport slave (
      input  req_valid, addr, write_en, funct3, data_input,
      output req_ready, resp_valid, data_output, misaligned, access_fault
   );
endinterface

// File: rtl/data_memory_sized_mem_byte_align.sv
// rtl/data_memory_sized_mem_byte_align.sv - combinational byte-lane steering and load extension
// Purpose: store-side lane steering and byte enables; load-side lane
//          extraction with sign/zero extension.
// Ports: lane (byte offset in word), funct3, store_data, word_data (current
//        array word) in; store_word, byte_en, load_data out.
module mem_byte_align
   import riscv_mem_pkg::*;
#(
   parameter int WORDSIZE = 64
) (
   input  logic [$clog2(WORDSIZE/8)-1:0] lane,
   input  logic [2:0]                    funct3,
   input  logic [WORDSIZE-1:0]           store_data,
   input  logic [WORDSIZE-1:0]           word_data,
   output logic [WORDSIZE-1:0]           store_word,
   output logic [WORDSIZE/8-1:0]         byte_en,
   output logic [WORDSIZE-1:0]           load_data
);
   localparam int NBYTES = WORDSIZE / 8;
   localparam int LANE_W = $clog2(NBYTES);

   logic [LANE_W+2:0]          bit_off;
   logic [3:0]                 size;
   logic [7:0]                 mask8;
   logic [7:0]                 ext_sh;
   logic [WORDSIZE-1:0]        lane_data;
   logic [WORDSIZE-1:0]        left_just;
   logic signed [WORDSIZE-1:0] sext;

   always_comb begin
      size    = access_size(funct3);
      bit_off = {lane, 3'b000};
      case (size)
         4'd1:    mask8 = 8'h01;
         4'd2:    mask8 = 8'h03;
         4'd4:    mask8 = 8'h0F;
         default: mask8 = 8'hFF;
      endcase
      byte_en    = mask8[NBYTES-1:0] << lane;
      store_word = store_data << bit_off;

      // Left-justify the accessed field, then shift back down: arithmetic
      // shift gives sign extension, logical shift gives zero extension.
      lane_data = word_data >> bit_off;
      if (8 * size >= WORDSIZE)
         ext_sh = 8'd0;
      else
         ext_sh = 8'(WORDSIZE - 8 * size);
      left_just = lane_data << ext_sh;
      sext      = $signed(left_just) >>> ext_sh;
      if (funct3[2])
         load_data = left_just >> ext_sh;
      else
         load_data = $unsigned(sext);
   end

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte-addressable data memory with sized access and fixed latency
// Purpose: accepts one load/store at a time, responds LATENCY cycles later
//          with extended load data and misaligned/access_fault flags.
// Ports: clk, rst (synchronous, active-high), bus (slave side of
//        data_memory_sized_if).
module data_memory_sized
   import riscv_mem_pkg::*;
#(
   parameter int WORDSIZE = 64,
   parameter int DEPTH    = 1024,
   parameter int LATENCY  = 1
) (
   input  logic               clk,
   input  logic               rst,
   data_memory_sized_if.slave bus
);
   localparam int NBYTES = WORDSIZE / 8;
   localparam int LANE_W = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(DEPTH);

   logic [WORDSIZE-1:0] mem [DEPTH];

   state_t              state;
   logic [2:0]          cnt;
   logic [WORDSIZE-1:0] addr_q;
   logic [WORDSIZE-1:0] din_q;
   logic                we_q;
   logic [2:0]          f3_q;

   logic                accept;
   logic                go_resp;
   logic [WORDSIZE-1:0] cur_addr;
   logic [WORDSIZE-1:0] cur_din;
   logic                cur_we;
   logic [2:0]          cur_f3;

   logic [LANE_W-1:0]   lane;
   logic [WORDSIZE-1:0] word_idx;
   logic [IDX_W-1:0]    idx;
   logic [3:0]          size_m1;
   logic                illegal_f3;
   logic                out_of_range;
   logic                fault;
   logic                misalign;

   logic [WORDSIZE-1:0] rd_word;
   logic [WORDSIZE-1:0] store_word;
   logic [NBYTES-1:0]   byte_en;
   logic [WORDSIZE-1:0] load_data;
   logic [WORDSIZE-1:0] resp_data;

   assign accept = bus.req_valid && bus.req_ready;

   // With LATENCY = 1 the response edge is the accept edge, so the request
   // is decoded straight from the bus while idle and from the latches later.
   always_comb begin
      if (state == IDLE) begin
         cur_addr = bus.addr;
         cur_din  = bus.data_input;
         cur_we   = bus.write_en;
         cur_f3   = bus.funct3;
      end else begin
         cur_addr = addr_q;
         cur_din  = din_q;
         cur_we   = we_q;
         cur_f3   = f3_q;
      end
   end

   assign lane         = cur_addr[LANE_W-1:0];
   assign word_idx     = cur_addr >> LANE_W;
   assign idx          = word_idx[IDX_W-1:0];
   assign size_m1      = access_size(cur_f3) - 4'd1;
   assign illegal_f3   = (cur_f3 == F3_ILL) ||
                         ((WORDSIZE == 32) && ((cur_f3 == F3_LD) || (cur_f3 == F3_LWU)));
   assign out_of_range = word_idx >= WORDSIZE'(DEPTH);
   assign fault        = illegal_f3 || out_of_range;
   assign misalign     = !fault && ((4'(lane) & size_m1) != 4'd0);

   assign go_resp = !rst && (((state == IDLE) && accept && (LATENCY == 1)) ||
                             ((state == WAIT) && (cnt == 3'd0)));

   assign rd_word   = mem[idx];
   assign resp_data = (!cur_we && !fault && !misalign) ? load_data : '0;

   mem_byte_align #(
      .WORDSIZE (WORDSIZE)
   ) u_align (
      .lane       (lane),
      .funct3     (cur_f3),
      .store_data (cur_din),
      .word_data  (rd_word),
      .store_word (store_word),
      .byte_en    (byte_en),
      .load_data  (load_data)
   );

   // Array has no reset; only enabled lanes of a clean store are written.
   always_ff @(posedge clk) begin
      if (go_resp && cur_we && !fault && !misalign) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (byte_en[b])
               mem[idx][b*8 +: 8] <= store_word[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= 3'd0;
         bus.req_ready    <= 1'b1;
         bus.resp_valid   <= 1'b0;
         bus.data_output  <= '0;
         bus.misaligned   <= 1'b0;
         bus.access_fault <= 1'b0;
      end else begin
         bus.resp_valid   <= 1'b0;
         bus.data_output  <= '0;
         bus.misaligned   <= 1'b0;
         bus.access_fault <= 1'b0;
         if (go_resp) begin
            bus.resp_valid   <= 1'b1;
            bus.data_output  <= resp_data;
            bus.misaligned   <= misalign;
            bus.access_fault <= fault;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q        <= bus.addr;
                  din_q         <= bus.data_input;
                  we_q          <= bus.write_en;
                  f3_q          <= bus.funct3;
                  bus.req_ready <= 1'b0;
                  if (LATENCY > 1) begin
                     state <= WAIT;
                     cnt   <= 3'(LATENCY - 2);
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               if (cnt == 3'd0)
                  state <= RESP;
               else
                  cnt <= cnt - 3'd1;
            end
            default: begin
               state         <= IDLE;
               bus.req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - directed self-checking bench for data_memory_sized
// Purpose: drives sized loads/stores with WORDSIZE=64, DEPTH=1024, LATENCY=2
//          and compares responses against hand-computed values.
module tb_data_memory_sized;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   data_memory_sized_if #(.WORDSIZE(64)) bus ();

   data_memory_sized #(
      .WORDSIZE (64),
      .DEPTH    (1024),
      .LATENCY  (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Issues one request and waits for its response; q/m/f are the response
   // fields and lat counts cycles from accept to resp_valid.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] q, output logic m,
                         output logic f, output int lat);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.write_en   = we;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.data_input = d;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         n_cmp++; n_err++;
         $display("FAIL req_ready_timeout addr=%h", a);
      end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      q = bus.data_output;
      m = bus.misaligned;
      f = bus.access_fault;
      if (!bus.resp_valid) begin
         n_cmp++; n_err++;
         $display("FAIL resp_timeout addr=%h", a);
         lat = -1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
      n_cmp++; if (bus.data_output !== 64'h0) begin n_err++; $display("FAIL rst_data got=%h exp=0", bus.data_output); end
      n_cmp++; if (bus.misaligned !== 1'b0) begin n_err++; $display("FAIL rst_misaligned got=%b exp=0", bus.misaligned); end
      n_cmp++; if (bus.access_fault !== 1'b0) begin n_err++; $display("FAIL rst_access_fault got=%b exp=0", bus.access_fault); end
   endtask

   task automatic test_sd_ld();
      logic [63:0] q; logic m, f; int lat;
      do_req(1'b1, 3'b011, 64'h10, 64'h8877665544332211, q, m, f, lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL sd_latency got=%0d exp=2", lat); end
      n_cmp++; if (q !== 64'h0) begin n_err++; $display("FAIL sd_data got=%h exp=0", q); end
      do_req(1'b0, 3'b011, 64'h10, 64'h0, q, m, f, lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL ld_latency got=%0d exp=2", lat); end
      n_cmp++; if (q !== 64'h8877665544332211) begin n_err++; $display("FAIL ld_data got=%h exp=8877665544332211", q); end
      n_cmp++; if ({m, f} !== 2'b00) begin n_err++; $display("FAIL ld_flags got=%b exp=00", {m, f}); end
   endtask

   task automatic test_sub_word();
      logic [63:0] q; logic m, f; int lat;
      do_req(1'b1, 3'b000, 64'h13, 64'h00000000000000AB, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b00) begin n_err++; $display("FAIL sb_flags got=%b exp=00", {m, f}); end
      do_req(1'b0, 3'b000, 64'h13, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'hFFFFFFFFFFFFFFAB) begin n_err++; $display("FAIL lb_data got=%h exp=ffffffffffffffab", q); end
      do_req(1'b0, 3'b100, 64'h13, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h00000000000000AB) begin n_err++; $display("FAIL lbu_data got=%h exp=ab", q); end
      do_req(1'b0, 3'b011, 64'h10, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h88776655AB332211) begin n_err++; $display("FAIL ld_after_sb got=%h exp=88776655ab332211", q); end
      do_req(1'b0, 3'b001, 64'h12, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'hFFFFFFFFFFFFAB33) begin n_err++; $display("FAIL lh_data got=%h exp=ffffffffffffab33", q); end
      do_req(1'b0, 3'b010, 64'h14, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'hFFFFFFFF88776655) begin n_err++; $display("FAIL lw_data got=%h exp=ffffffff88776655", q); end
      do_req(1'b0, 3'b110, 64'h14, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h0000000088776655) begin n_err++; $display("FAIL lwu_data got=%h exp=88776655", q); end
      do_req(1'b0, 3'b101, 64'h12, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h000000000000AB33) begin n_err++; $display("FAIL lhu_data got=%h exp=ab33", q); end
   endtask

   task automatic test_misaligned();
      logic [63:0] q; logic m, f; int lat;
      do_req(1'b0, 3'b001, 64'h11, 64'h0, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b10) begin n_err++; $display("FAIL lh_mis_flags got=%b exp=10", {m, f}); end
      n_cmp++; if (q !== 64'h0) begin n_err++; $display("FAIL lh_mis_data got=%h exp=0", q); end
      do_req(1'b1, 3'b010, 64'h11, 64'h00000000DEADBEEF, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b10) begin n_err++; $display("FAIL sw_mis_flags got=%b exp=10", {m, f}); end
      do_req(1'b0, 3'b011, 64'h10, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h88776655AB332211) begin n_err++; $display("FAIL ld_after_mis_sw got=%h exp=88776655ab332211", q); end
   endtask

   task automatic test_access_fault();
      logic [63:0] q; logic m, f; int lat;
      do_req(1'b0, 3'b011, 64'h2000, 64'h0, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b01) begin n_err++; $display("FAIL oor_flags got=%b exp=01", {m, f}); end
      n_cmp++; if (q !== 64'h0) begin n_err++; $display("FAIL oor_data got=%h exp=0", q); end
      do_req(1'b0, 3'b111, 64'h11, 64'h0, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b01) begin n_err++; $display("FAIL f3_ill_flags got=%b exp=01", {m, f}); end
      do_req(1'b1, 3'b011, 64'h1FF8, 64'h0123456789ABCDEF, q, m, f, lat);
      n_cmp++; if ({m, f} !== 2'b00) begin n_err++; $display("FAIL top_sd_flags got=%b exp=00", {m, f}); end
      do_req(1'b0, 3'b011, 64'h1FF8, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL top_ld_data got=%h exp=0123456789abcdef", q); end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  rdy_pat = '0;
      logic [5:0]  rsp_pat = '0;
      logic [63:0] last_q  = '0;
      int          n_resp  = 0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.write_en   = 1'b0;
      bus.funct3     = 3'b011;
      bus.addr       = 64'h10;
      bus.data_input = 64'h0;
      for (int i = 0; i < 10; i++) begin
         if (i == 6) bus.req_valid = 1'b0;
         if (i < 6) begin
            rdy_pat = {rdy_pat[4:0], bus.req_ready};
            rsp_pat = {rsp_pat[4:0], bus.resp_valid};
         end
         if (bus.resp_valid) begin
            n_resp++;
            last_q = bus.data_output;
         end
         @(negedge clk);
      end
      n_cmp++; if (rdy_pat !== 6'b100100) begin n_err++; $display("FAIL b2b_ready got=%b exp=100100", rdy_pat); end
      n_cmp++; if (rsp_pat !== 6'b001001) begin n_err++; $display("FAIL b2b_resp got=%b exp=001001", rsp_pat); end
      n_cmp++; if (n_resp !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", n_resp); end
      n_cmp++; if (last_q !== 64'h88776655AB332211) begin n_err++; $display("FAIL b2b_data got=%h exp=88776655ab332211", last_q); end
   endtask

   task automatic test_reset_mid();
      logic [63:0] q; logic m, f; int lat;
      int n_resp = 0;
      do_req(1'b1, 3'b011, 64'h18, 64'h5, q, m, f, lat);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.write_en   = 1'b1;
      bus.funct3     = 3'b011;
      bus.addr       = 64'h18;
      bus.data_input = 64'h1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_resp got=%b exp=0", bus.resp_valid); end
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", bus.req_ready); end
      n_cmp++; if (bus.data_output !== 64'h0) begin n_err++; $display("FAIL rstmid_data got=%h exp=0", bus.data_output); end
      n_cmp++; if ({bus.misaligned, bus.access_fault} !== 2'b00) begin n_err++; $display("FAIL rstmid_flags got=%b exp=00", {bus.misaligned, bus.access_fault}); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.resp_valid) n_resp++;
      end
      n_cmp++; if (n_resp !== 0) begin n_err++; $display("FAIL rstmid_late_resp got=%0d exp=0", n_resp); end
      do_req(1'b0, 3'b011, 64'h18, 64'h0, q, m, f, lat);
      n_cmp++; if (q !== 64'h5) begin n_err++; $display("FAIL rstmid_ld got=%h exp=5", q); end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.write_en   = 1'b0;
      bus.funct3     = 3'b000;
      bus.addr       = '0;
      bus.data_input = '0;
      test_reset();
      test_sd_ld();
      test_sub_word();
      test_misaligned();
      test_access_fault();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
